// File: rtl/pcs_tx_blk_enc.sv
// Packs BEAT_N MAC beats into one 64-bit block and encodes it as a 66b block
// (sync header + block type) for the scrambler/gearbox, with a frame-state check.
module pcs_tx_blk_enc #(
  parameter int DATA_W      = 16,
  parameter int KEEP_W      = DATA_W/8,
  parameter int BLOCK_N     = 8,
  parameter int BEAT_N      = BLOCK_N/KEEP_W,
  parameter int BLOCK_LEN_W = $clog2(BLOCK_N+1)
) (
  input  logic                   clk,
  input  logic                   nreset,
  input  logic                   mac_ctrl_v_i,
  input  logic [DATA_W-1:0]      mac_data_i,
  input  logic                   mac_start_i,
  input  logic                   mac_idle_i,
  input  logic                   mac_term_i,
  input  logic [BLOCK_LEN_W-1:0] mac_term_len_i,
  output logic                   mac_ready_o,
  input  logic                   pcs_ready_i,
  output logic                   pcs_valid_o,
  output logic [65:0]            pcs_block_o,
  output logic                   err_o
);
  localparam int CNT_W = (BEAT_N > 1) ? $clog2(BEAT_N) : 1;
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_FRAME = 1'b1;

  logic [CNT_W-1:0]       beat_cnt_q, beat_cnt_d;
  logic [BLOCK_N*8-1:0]   blk_q, blk_d, blk_n;
  logic                   any_ctrl_q, any_ctrl_d, any_ctrl_n;
  logic                   any_start_q, any_start_d, any_start_n;
  logic                   any_term_q, any_term_d, any_term_n;
  logic                   any_data_q, any_data_d, any_data_n;
  logic                   any_idle_q, any_idle_d, any_idle_n;
  logic                   start_bad_q, start_bad_d, start_bad_n;
  logic [BLOCK_LEN_W-1:0] term_len_q, term_len_d, term_len_n;
  logic [0:0]             state_q, state_d;
  logic                   pcs_valid_q, pcs_valid_d;
  logic [65:0]            pcs_block_q, pcs_block_d;
  logic                   err_q, err_d;

  logic                   first, last;
  logic                   idle_blk, start_blk, data_blk, bad_blk, enc_err;
  logic [63:0]            pay;
  logic [1:0]             sync;
  logic [7:0]             term_type;

  assign mac_ready_o = pcs_ready_i;
  assign pcs_valid_o = pcs_valid_q;
  assign pcs_block_o = pcs_block_q;
  assign err_o       = err_q;

  always_comb begin
    first = (beat_cnt_q == '0);
    last  = (beat_cnt_q == CNT_W'(BEAT_N-1));

    // Block view including the beat currently offered; per-block state restarts on beat 0.
    blk_n = blk_q;
    for (int k = 0; k < BEAT_N; k++)
      if (beat_cnt_q == CNT_W'(k)) blk_n[k*DATA_W +: DATA_W] = mac_data_i;
    any_ctrl_n  = (first ? 1'b0 : any_ctrl_q)  | mac_ctrl_v_i;
    any_start_n = (first ? 1'b0 : any_start_q) | mac_start_i;
    any_term_n  = (first ? 1'b0 : any_term_q)  | mac_term_i;
    any_data_n  = (first ? 1'b0 : any_data_q)  | ~mac_idle_i;
    any_idle_n  = (first ? 1'b0 : any_idle_q)  | mac_idle_i;
    start_bad_n = (first ? 1'b0 : start_bad_q) | (mac_start_i & ~first);
    term_len_n  = (mac_term_i && !(first ? 1'b0 : any_term_q)) ? mac_term_len_i : term_len_q;

    idle_blk  = ~any_data_n & ~any_start_n & ~any_term_n;
    start_blk = any_start_n & ~start_bad_n & ~any_term_n;
    data_blk  = ~any_ctrl_n & ~any_idle_n & ~any_start_n & ~any_term_n;
    bad_blk   = start_bad_n
              | (any_start_n & any_term_n)
              | (any_data_n & any_idle_n & ~any_term_n)
              | (any_term_n & (term_len_n > BLOCK_LEN_W'(BLOCK_N-1)))
              | ((state_q == ST_FRAME) & start_blk)
              | ((state_q == ST_IDLE) & data_blk);

    case (term_len_n)
      BLOCK_LEN_W'(0): term_type = 8'h87;
      BLOCK_LEN_W'(1): term_type = 8'h99;
      BLOCK_LEN_W'(2): term_type = 8'hAA;
      BLOCK_LEN_W'(3): term_type = 8'hB4;
      BLOCK_LEN_W'(4): term_type = 8'hCC;
      BLOCK_LEN_W'(5): term_type = 8'hD2;
      BLOCK_LEN_W'(6): term_type = 8'hE1;
      BLOCK_LEN_W'(7): term_type = 8'hFF;
      default:         term_type = 8'h1E;
    endcase

    sync    = 2'b10;
    pay     = '0;
    enc_err = 1'b0;
    if (idle_blk) begin
      pay[7:0] = 8'h1E;
    end else if (bad_blk) begin
      pay     = {8{8'h1E}};
      enc_err = 1'b1;
    end else if (start_blk) begin
      pay = {blk_n[63:8], 8'h78};
    end else if (any_term_n) begin
      // Terminate: type byte, then the first L data bytes, zero fill.
      pay[7:0] = term_type;
      for (int i = 1; i < 8; i++)
        if (BLOCK_LEN_W'(i) <= term_len_n) pay[i*8 +: 8] = blk_n[(i-1)*8 +: 8];
    end else if (data_blk) begin
      sync = 2'b01;
      pay  = blk_n[63:0];
    end else begin
      pay     = {8{8'h1E}};
      enc_err = 1'b1;
    end

    beat_cnt_d  = beat_cnt_q;
    blk_d       = blk_q;
    any_ctrl_d  = any_ctrl_q;
    any_start_d = any_start_q;
    any_term_d  = any_term_q;
    any_data_d  = any_data_q;
    any_idle_d  = any_idle_q;
    start_bad_d = start_bad_q;
    term_len_d  = term_len_q;
    state_d     = state_q;
    pcs_valid_d = pcs_valid_q;
    pcs_block_d = pcs_block_q;
    err_d       = err_q;

    // A stalled gearbox freezes everything, including a pending output block.
    if (pcs_ready_i) begin
      beat_cnt_d  = last ? '0 : beat_cnt_q + CNT_W'(1);
      blk_d       = blk_n;
      any_ctrl_d  = any_ctrl_n;
      any_start_d = any_start_n;
      any_term_d  = any_term_n;
      any_data_d  = any_data_n;
      any_idle_d  = any_idle_n;
      start_bad_d = start_bad_n;
      term_len_d  = term_len_n;
      pcs_valid_d = last;
      err_d       = last & enc_err;
      if (last) begin
        pcs_block_d = {pay, sync};
        if (enc_err)         state_d = ST_IDLE;
        else if (start_blk)  state_d = ST_FRAME;
        else if (any_term_n) state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      beat_cnt_q  <= '0;
      blk_q       <= '0;
      any_ctrl_q  <= 1'b0;
      any_start_q <= 1'b0;
      any_term_q  <= 1'b0;
      any_data_q  <= 1'b0;
      any_idle_q  <= 1'b0;
      start_bad_q <= 1'b0;
      term_len_q  <= '0;
      state_q     <= ST_IDLE;
      pcs_valid_q <= 1'b0;
      pcs_block_q <= '0;
      err_q       <= 1'b0;
    end else begin
      beat_cnt_q  <= beat_cnt_d;
      blk_q       <= blk_d;
      any_ctrl_q  <= any_ctrl_d;
      any_start_q <= any_start_d;
      any_term_q  <= any_term_d;
      any_data_q  <= any_data_d;
      any_idle_q  <= any_idle_d;
      start_bad_q <= start_bad_d;
      term_len_q  <= term_len_d;
      state_q     <= state_d;
      pcs_valid_q <= pcs_valid_d;
      pcs_block_q <= pcs_block_d;
      err_q       <= err_d;
    end
  end
endmodule

// File: tb/tb_pcs_tx_blk_enc.sv
// Directed vectors for pcs_tx_blk_enc with hand-computed 66b blocks.
module tb_pcs_tx_blk_enc;
  logic        clk = 1'b0;
  logic        nreset;
  logic        ctrl_v, start, idle, term, rdy;
  logic [15:0] data;
  logic [3:0]  tlen;
  logic        mac_rdy, vld, err;
  logic [65:0] blk;
  int          n_chk = 0, n_pass = 0;

  localparam logic [65:0] IDLE_B = {56'h0, 8'h1E, 2'b10};
  localparam logic [65:0] ERR_B  = {64'h1E1E1E1E1E1E1E1E, 2'b10};
  localparam logic [65:0] STRT_B = {64'hD555555555555578, 2'b10};

  pcs_tx_blk_enc dut (
    .clk(clk), .nreset(nreset),
    .mac_ctrl_v_i(ctrl_v), .mac_data_i(data), .mac_start_i(start),
    .mac_idle_i(idle), .mac_term_i(term), .mac_term_len_i(tlen),
    .mac_ready_o(mac_rdy), .pcs_ready_i(rdy),
    .pcs_valid_o(vld), .pcs_block_o(blk), .err_o(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [65:0] got, input logic [65:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic beat(input logic c, input logic [15:0] d, input logic s,
                      input logic i, input logic t, input logic [3:0] l);
    ctrl_v = c; data = d; start = s; idle = i; term = t; tlen = l;
    @(posedge clk); #1;
  endtask

  task automatic idle4();
    for (int k = 0; k < 4; k++) beat(1, 16'h0, 0, 1, 0, 0);
  endtask

  task automatic start4();
    beat(1, 16'h5555, 1, 0, 0, 0);
    beat(1, 16'h5555, 0, 0, 0, 0);
    beat(1, 16'h5555, 0, 0, 0, 0);
    beat(1, 16'hD555, 0, 0, 0, 0);
  endtask

  initial begin
    nreset = 0; rdy = 1;
    ctrl_v = 0; data = 16'hFFFF; start = 1; idle = 0; term = 1; tlen = 4'd9;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 66'(vld), 66'(1'b0));
    chk("rst_block", blk, 66'h0);
    chk("rst_err", 66'(err), 66'(1'b0));
    chk("rst_ready", 66'(mac_rdy), 66'(1'b1));
    nreset = 1;

    // 1: all-idle block
    idle4();
    chk("t1_valid", 66'(vld), 66'(1'b1));
    chk("t1_block", blk, IDLE_B);
    chk("t1_err", 66'(err), 66'(1'b0));

    // 2: start block
    start4();
    chk("t2_block", blk, STRT_B);
    chk("t2_err", 66'(err), 66'(1'b0));

    // 3: data block in frame
    beat(0, 16'h0201, 0, 0, 0, 0);
    chk("t3_vld_mid", 66'(vld), 66'(1'b0));
    beat(0, 16'h0403, 0, 0, 0, 0);
    beat(0, 16'h0605, 0, 0, 0, 0);
    beat(0, 16'h0807, 0, 0, 0, 0);
    chk("t3_block", blk, {64'h0807060504030201, 2'b01});

    // 4: terminate L=3, byte 3 (EE) must be dropped
    beat(1, 16'hAABB, 0, 0, 1, 4'd3);
    beat(1, 16'hEECC, 0, 0, 1, 4'd5);
    beat(1, 16'h0000, 0, 1, 1, 4'd5);
    beat(1, 16'h0000, 0, 1, 1, 4'd5);
    chk("t4_block", blk, {64'h00000000CCAABBB4, 2'b10});
    chk("t4_err", 66'(err), 66'(1'b0));

    // 5: stall mid start-block (also proves FSM went back to IDLE)
    beat(1, 16'h1122, 1, 0, 0, 0);
    beat(1, 16'h3344, 0, 0, 0, 0);
    rdy = 0;
    for (int k = 0; k < 3; k++) begin
      beat(0, 16'hDEAD, 1, 1, 1, 4'd2);
      chk("t5_mac_ready", 66'(mac_rdy), 66'(1'b0));
      chk("t5_hold_vld", 66'(vld), 66'(1'b0));
    end
    rdy = 1;
    beat(1, 16'h5566, 0, 0, 0, 0);
    chk("t5_cnt_held", 66'(vld), 66'(1'b0));
    beat(1, 16'h7788, 0, 0, 0, 0);
    chk("t5_block", blk, {64'h7788556633441178, 2'b10});
    chk("t5_err", 66'(err), 66'(1'b0));

    // Terminate with no data bytes
    for (int k = 0; k < 4; k++) beat(1, 16'h0, 0, 1, 1, 4'd0);
    chk("term0_block", blk, {56'h0, 8'h87, 2'b10});

    // New frame ended by a full L=7 terminate
    start4();
    chk("s2_block", blk, STRT_B);
    beat(1, 16'h0201, 0, 0, 1, 4'd7);
    beat(1, 16'h0403, 0, 0, 1, 4'd0);
    beat(1, 16'h0605, 0, 0, 1, 4'd0);
    beat(1, 16'h0807, 0, 0, 1, 4'd0);
    chk("term7_block", blk, {64'h07060504030201FF, 2'b10});
    chk("term7_err", 66'(err), 66'(1'b0));

    // 6: start on beat 2 -> error block, one-cycle err pulse
    beat(1, 16'h5555, 0, 0, 0, 0);
    beat(1, 16'h5555, 0, 0, 0, 0);
    beat(1, 16'h5555, 1, 0, 0, 0);
    beat(1, 16'hD555, 0, 0, 0, 0);
    chk("t6_block", blk, ERR_B);
    chk("t6_err", 66'(err), 66'(1'b1));
    chk("t6_valid", 66'(vld), 66'(1'b1));
    beat(1, 16'h0, 0, 1, 0, 0);
    chk("t6_err_drop", 66'(err), 66'(1'b0));
    chk("t6_vld_drop", 66'(vld), 66'(1'b0));

    // Reset mid-block: partial block discarded, count restarts
    nreset = 0;
    beat(1, 16'h0, 0, 1, 0, 0);
    nreset = 1;
    chk("rst_mid_block", blk, 66'h0);
    beat(1, 16'h0, 0, 1, 0, 0);
    beat(1, 16'h0, 0, 1, 0, 0);
    chk("rst_mid_no_vld", 66'(vld), 66'(1'b0));
    beat(1, 16'h0, 0, 1, 0, 0);
    beat(1, 16'h0, 0, 1, 0, 0);
    chk("rst_mid_vld", 66'(vld), 66'(1'b1));
    chk("rst_mid_idle", blk, IDLE_B);

    // Data block outside a frame
    beat(0, 16'h0201, 0, 0, 0, 0);
    beat(0, 16'h0403, 0, 0, 0, 0);
    beat(0, 16'h0605, 0, 0, 0, 0);
    beat(0, 16'h0807, 0, 0, 0, 0);
    chk("data_idle_block", blk, ERR_B);
    chk("data_idle_err", 66'(err), 66'(1'b1));

    // term_len out of range
    for (int k = 0; k < 4; k++) beat(1, 16'h1234, 0, 0, 1, 4'd8);
    chk("tlen8_block", blk, ERR_B);
    chk("tlen8_err", 66'(err), 66'(1'b1));

    // Idle mixed with data, no term
    beat(1, 16'h1111, 0, 0, 0, 0);
    beat(1, 16'h0, 0, 1, 0, 0);
    beat(1, 16'h0, 0, 1, 0, 0);
    beat(1, 16'h0, 0, 1, 0, 0);
    chk("mix_block", blk, ERR_B);

    idle4();
    chk("final_idle", blk, IDLE_B);
    chk("final_err", 66'(err), 66'(1'b0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
